hilo_mul_ctrl: RTL

//  Sequencer for the iterative multiplier and the HI/LO register pair.

---
 rtl/hilo_mul_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: sequencer for an iterative shift-add multiplier and the
// HI/LO register pair. It executes MULT, MULTU, MADD, MADDU, MSUB, MSUBU,
// MTHI and MTLO.
//
// Issue handshake: the decoder pulses Start for one cycle. The op is
// accepted only when the sequencer is in IDLE. Stall is a registered
// "busy" flag, so it is low in the issue cycle itself. The pipeline holds
// the next instruction while Stall=1. A Start that arrives while the
// sequencer is not in IDLE is dropped without any effect.
// Done pulses for one cycle, in the first cycle that Hi/Lo hold a
// multiply result.
module hilo_mul_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             MULOp,
    input  logic [5:0]       Func,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       dbg_state
);

    localparam int ITER = WIDTH / STEP;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_MUL = 2'd0,
        CLS_ADD = 2'd1,
        CLS_SUB = 2'd2
    } cls_t;

    state_t             state, state_n;
    cls_t               cls, cls_n;
    logic               neg, neg_n;
    logic [2*WIDTH-1:0] ma, ma_n;
    logic [WIDTH-1:0]   mb, mb_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   hi, hi_n;
    logic [WIDTH-1:0]   lo, lo_n;
    logic               stall, stall_n;
    logic               done, done_n;

    // Decoded function codes
    logic is_mult, is_multu, is_mthi, is_mtlo;
    logic is_madd, is_maddu, is_msub, is_msubu;
    logic is_mul_op, is_signed_op;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] step_sum;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] hilo_new;

    // Decode the issued instruction from MULOp/Func.
    always_comb begin
        is_mult      = !MULOp && (Func == 6'h18);
        is_multu     = !MULOp && (Func == 6'h19);
        is_mthi      = !MULOp && (Func == 6'h11);
        is_mtlo      = !MULOp && (Func == 6'h13);
        is_madd      =  MULOp && (Func == 6'h00);
        is_maddu     =  MULOp && (Func == 6'h01);
        is_msub      =  MULOp && (Func == 6'h04);
        is_msubu     =  MULOp && (Func == 6'h05);
        is_mul_op    = is_mult | is_multu | is_madd | is_maddu | is_msub | is_msubu;
        is_signed_op = is_mult | is_madd | is_msub;
    end

    // Operand magnitudes; the most negative value maps onto itself and is
    // then correct when read as unsigned.
    always_comb begin
        a_abs = A[WIDTH-1] ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
        b_abs = B[WIDTH-1] ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
    end

    // One shift-add step: add the shifted multiplicand for each of the
    // STEP low multiplier bits.
    always_comb begin
        step_sum = acc;
        for (int i = 0; i < STEP; i++) begin
            if (mb[i]) begin
                step_sum = step_sum + (ma << i);
            end
        end
    end

    // Apply the sign to the product and combine it with HI/LO by op class.
    always_comb begin
        prod_signed = neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
        case (cls)
            CLS_ADD: hilo_new = {hi, lo} + prod_signed;
            CLS_SUB: hilo_new = {hi, lo} - prod_signed;
            default: hilo_new = prod_signed;
        endcase
    end

    // Next-state and datapath updates for the IDLE -> RUN -> FIN sequence.
    always_comb begin
        state_n = state;
        cls_n   = cls;
        neg_n   = neg;
        ma_n    = ma;
        mb_n    = mb;
        acc_n   = acc;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        stall_n = stall;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                stall_n = 1'b0;
                if (Start) begin
                    if (is_mthi) begin
                        hi_n = A;
                    end
                    if (is_mtlo) begin
                        lo_n = A;
                    end
                    if (is_mul_op) begin
                        if (is_signed_op) begin
                            ma_n  = {{WIDTH{1'b0}}, a_abs};
                            mb_n  = b_abs;
                            neg_n = A[WIDTH-1] ^ B[WIDTH-1];
                        end else begin
                            ma_n  = {{WIDTH{1'b0}}, A};
                            mb_n  = B;
                            neg_n = 1'b0;
                        end
                        if (is_madd || is_maddu) begin
                            cls_n = CLS_ADD;
                        end else if (is_msub || is_msubu) begin
                            cls_n = CLS_SUB;
                        end else begin
                            cls_n = CLS_MUL;
                        end
                        acc_n   = '0;
                        cnt_n   = CW'(ITER);
                        stall_n = 1'b1;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                acc_n = step_sum;
                ma_n  = ma << STEP;
                mb_n  = mb >> STEP;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                hi_n    = hilo_new[2*WIDTH-1:WIDTH];
                lo_n    = hilo_new[WIDTH-1:0];
                done_n  = 1'b1;
                stall_n = 1'b0;
                state_n = IDLE;
            end
            default: begin
                stall_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cls   <= CLS_MUL;
            neg   <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            stall <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cls   <= cls_n;
            neg   <= neg_n;
            ma    <= ma_n;
            mb    <= mb_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            stall <= stall_n;
            done  <= done_n;
        end
    end

    assign Stall     = stall;
    assign Done      = done;
    assign Hi        = hi;
    assign Lo        = lo;
    assign dbg_state = state;

endmodule
